// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory read bus, redirect and decoder handshake of the fetch unit
interface instruction_fetch_if #(
  parameter int data_length = 32,
  parameter int AW = 6
);
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [data_length-1:0] mem_wdata;
  logic [data_length-1:0] mem_rdata;
  logic redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic instr_valid;
  logic instr_ready;
  logic [data_length-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  modport master (
    output mem_addr, mem_we, mem_wdata, instr_valid, instr_data, instr_pc,
    input mem_rdata, redirect_valid, redirect_addr, instr_ready
  );
  modport slave (
    input mem_addr, mem_we, mem_wdata, instr_valid, instr_data, instr_pc,
    output mem_rdata, redirect_valid, redirect_addr, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing reads to instruction memory, buffering words for the decoder
module instruction_fetch #(
  parameter int data_length = 32,
  parameter int mem_length = 64,
  parameter int opc_length = 5,
  parameter logic [opc_length-1:0] HALT_OPCODE = '0,
  parameter bit HALT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic halted_o,
  output logic busy_o,
  instruction_fetch_if.master bus
);
  localparam int AW = $clog2(mem_length);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_inc, addr_q, tag_q;
  logic inflight_q, rd_q, wr_q;
  logic [1:0] cnt_q, cnt_post;
  logic [data_length-1:0] data_q [2];
  logic [AW-1:0] pcs_q [2];
  logic fetch, flush, deq, cap, hit, stop, enq, issue, go_redirect, go_start;
  assign fetch = state_q == FETCH;
  assign flush = fetch && bus.redirect_valid;
  assign deq = bus.instr_valid && bus.instr_ready;
  assign cnt_post = cnt_q - 2'(deq);
  assign cap = fetch && inflight_q && !bus.redirect_valid;
  assign hit = HALT_EN && (bus.mem_rdata[data_length-1 -: opc_length] == HALT_OPCODE);
  assign stop = cap && hit;
  assign enq = cap && !hit;
  // counting the slot freed by this cycle's dequeue keeps one word per cycle under full ready
  assign issue = fetch && !bus.redirect_valid && (cnt_post + 2'(inflight_q)) < 2'd2;
  assign go_redirect = bus.redirect_valid && state_q != IDLE;
  assign go_start = start_i && state_q != FETCH;
  assign pc_inc = (pc_q == AW'(mem_length - 1)) ? '0 : pc_q + 1'b1;
  assign pc_d = go_redirect ? bus.redirect_addr : (go_start ? '0 : (issue ? pc_inc : pc_q));
  assign state_d = (go_redirect || go_start) ? FETCH : (stop ? HALT : state_q);
  assign bus.mem_addr = issue ? pc_q : addr_q;
  assign bus.mem_we = 1'b0;
  assign bus.mem_wdata = '0;
  assign bus.instr_valid = cnt_q != 2'd0;
  assign bus.instr_data = data_q[rd_q];
  assign bus.instr_pc = pcs_q[rd_q];
  assign halted_o = state_q == HALT && cnt_q == 2'd0;
  assign busy_o = fetch;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      addr_q <= '0;
      tag_q <= '0;
      inflight_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= '0;
      data_q <= '{default: '0};
      pcs_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= bus.mem_addr;
      inflight_q <= issue && !stop;
      cnt_q <= flush ? 2'd0 : cnt_post + 2'(enq);
      rd_q <= !flush && (rd_q ^ deq);
      wr_q <= !flush && (wr_q ^ enq);
      if (issue) tag_q <= pc_q;
      if (enq) begin
        data_q[wr_q] <= bus.mem_rdata;
        pcs_q[wr_q] <= tag_q;
      end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus with a queue scoreboard checked by a transfer monitor
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic halted, busy;
  instruction_fetch_if #(.data_length(32), .AW(6)) bus();
  instruction_fetch dut (.clk(clk), .rst_n(rst_n), .start_i(start), .halted_o(halted), .busy_o(busy), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] mem [64];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];
  int passed = 0;
  int total = 0;
  logic [5:0] exp_q [$];
  logic [5:0] mon_pc;
  function automatic logic [31:0] w(int a);
    return (a == 4 || a == 8 || a == 13) ? 32'h0 : 32'h0800_1000 + 32'(a);
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_run(int first, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(6'((first + i) % 64));
  endtask
  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.instr_valid) found = 1'b1;
      else tick();
    end
    check("wait_valid", 64'(found), 64'd1);
  endtask
  task automatic wait_halted();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = halted;
    end
    check("halted", 64'(ok), 64'd1);
    check("busy_in_halt", 64'(busy), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask
  always @(negedge clk)
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_xfer: got pc %0d, expected none", bus.instr_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        check("xfer_pc", 64'(bus.instr_pc), 64'(mon_pc));
        check("xfer_data", 64'(bus.instr_data), 64'(w(int'(mon_pc))));
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got no end, expected finish");
    $fatal(1);
  end
  initial begin
    bit found;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = w(i);
    #12;
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_data", 64'(bus.instr_data), 64'd0);
    check("rst_pc", 64'(bus.instr_pc), 64'd0);
    check("rst_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("mem_we", 64'(bus.mem_we), 64'd0);
    check("mem_wdata", 64'(bus.mem_wdata), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    // straight-line program with ready held high
    bus.instr_ready = 1'b1;
    start = 1'b1;
    push_run(0, 4);
    tick();
    start = 1'b0;
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_lat1", 64'(bus.instr_valid), 64'd0);
    tick();
    check("t1_lat2", 64'(bus.instr_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_valid", 64'(bus.instr_valid), 64'd1);
      check("t1_pc", 64'(bus.instr_pc), 64'(i));
    end
    tick();
    check("t1_no_pc4", 64'(bus.instr_valid), 64'd0);
    check("t1_halted", 64'(halted), 64'd1);
    check("t1_busy_off", 64'(busy), 64'd0);
    tick();
    check("t1_still_idle", 64'(bus.instr_valid), 64'd0);
    // redirect out of HALT
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 6'd5;
    push_run(5, 3);
    tick();
    bus.redirect_valid = 1'b0;
    check("t5_busy", 64'(busy), 64'd1);
    check("t5_halted", 64'(halted), 64'd0);
    wait_halted();
    // start and redirect together: redirect wins, and pc wraps 63 -> 0
    start = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 6'd63;
    push_run(63, 5);
    tick();
    start = 1'b0;
    bus.redirect_valid = 1'b0;
    wait_halted();
    // backpressure
    bus.instr_ready = 1'b0;
    start = 1'b1;
    push_run(0, 4);
    tick();
    start = 1'b0;
    wait_valid(found);
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", 64'(bus.instr_valid), 64'd1);
      check("t2_stall_pc", 64'(bus.instr_pc), 64'd0);
      check("t2_stall_data", 64'(bus.instr_data), 64'(w(0)));
      check("t2_stall_addr", 64'(bus.mem_addr <= 6'd1), 64'd1);
      tick();
    end
    bus.instr_ready = 1'b1;
    wait_halted();
    // redirect while pc2 is in flight
    start = 1'b1;
    exp_q.push_back(6'd0);
    exp_q.push_back(6'd1);
    push_run(10, 3);
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.instr_valid && bus.instr_pc == 6'd1) found = 1'b1;
      else tick();
    end
    check("t3_find_pc1", 64'(found), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 6'd10;
    tick();
    bus.redirect_valid = 1'b0;
    check("t3_r1_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    check("t3_r2_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    check("t3_r3_valid", 64'(bus.instr_valid), 64'd1);
    check("t3_r3_pc", 64'(bus.instr_pc), 64'd10);
    wait_halted();
    // asynchronous reset while stalled
    bus.instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(found);
    #3 rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(bus.instr_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_halted", 64'(halted), 64'd0);
    check("t6_pc", 64'(bus.instr_pc), 64'd0);
    check("t6_data", 64'(bus.instr_data), 64'd0);
    check("t6_addr", 64'(bus.mem_addr), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 6'd7;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t6_idle_valid", 64'(bus.instr_valid), 64'd0);
      check("t6_idle_busy", 64'(busy), 64'd0);
      tick();
    end
    check("sb_final", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
